mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 92 +++++++++
 tb/tb_mul_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier sequencer: one operand bit per cycle, low WIDTH bits of the product.
// Optional MUL_SEQUENCER_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier is zero.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_exit;
  logic             w_accept;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept   = start_i && !flush_i;

`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
  // Once the multiplier has shifted out to zero no further partial products can be added.
  assign w_exit = w_last || (r_mplier == '0);
`else
  assign w_exit = w_last;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= src1_i;
            r_mplier <= src2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            // The final partial product is folded in on the same edge that enters DONE.
            if (w_exit) begin
              r_state  <= S_DONE;
              r_result <= w_acc_next;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (r_state == S_RUN);
  assign done_o   = (r_state == S_DONE) && !flush_i;
  assign stall_o  = !rst_i && ((r_state == S_RUN) || ((r_state == S_IDLE) && w_accept));
  assign result_o = r_result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a cycle-level behavioural model checked every cycle.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [31:0] src1, src2;
  logic        stall, busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int cyc_n = 0;

`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
  localparam int LAT_7X9 = 6;
  localparam int LAT_0   = 2;
  localparam int LAT_1   = 3;
  localparam int LAT_2X3 = 4;
  localparam int FL_CYC  = 2;
  localparam int RST_CYC = 3;
`else
  localparam int LAT_7X9 = 33;
  localparam int LAT_0   = 33;
  localparam int LAT_1   = 33;
  localparam int LAT_2X3 = 33;
  localparam int FL_CYC  = 12;
  localparam int RST_CYC = 10;
`endif

  mul_sequencer #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .src1_i(src1), .src2_i(src2),
    .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Number of RUN cycles an operation with multiplier b spends before DONE.
  function automatic int runs(input logic [31:0] b);
    int r;
    r = 32;
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
    r = 1;
    for (int i = 0; i < 32; i++) if (b[i]) r = i + 2;
    if (r > 32) r = 32;
`endif
    return r;
  endfunction

  // Model: 0 idle, 1 running, 2 done
  int          m_st = 0;
  int          m_k = 0;
  int          m_runs = 0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk) begin
    if (!rst) begin
      case (m_st)
        0: if (start && !flush) begin
          m_st = 1; m_k = 0; m_prod = src1 * src2; m_runs = runs(src2);
        end
        1: if (flush) m_st = 0;
           else begin
             m_k++;
             if (m_k == m_runs) begin m_st = 2; m_res = m_prod; end
           end
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin m_st = 0; m_res = '0; end
    chk("busy", busy, m_st == 1);
    chk("done", done, (m_st == 2) && !flush);
    chk("stall", stall, !rst && ((m_st == 1) || ((m_st == 0) && start && !flush)));
    chk("result", result, m_res);
    if (done) n_done++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, output int lat);
    int c0;
    bit got;
    got = 0; lat = -1;
    start = 1'b1; src1 = a; src2 = b; c0 = cyc_n;
    #1 chk("stall_start", stall, 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) begin
        lat = cyc_n - c0; got = 1;
        chk("stall_in_done", stall, 0);
        break;
      end
    end
    chk("done_seen", got, 1);
    tick();
  endtask

  int lat, c0, d0;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; src1 = '0; src2 = '0;
    repeat (2) tick();
    start = 1'b1;
    #1 chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    tick();
    start = 1'b0; rst = 1'b0;
    tick();

    op(32'd7, 32'd9, lat);
    chk("lat_7x9", lat, LAT_7X9);
    chk("res_7x9", result, 63);

    // Flush mid-RUN with a simultaneous start that must be dropped
    start = 1'b1; src1 = 5; src2 = 5; c0 = cyc_n;
    tick(); start = 1'b0;
    repeat (FL_CYC - 1) tick();
    flush = 1'b1; start = 1'b1; src1 = 4; src2 = 4;
    tick(); flush = 1'b0; start = 1'b0;
    chk("flush_idle", busy, 0);
    d0 = n_done;
    repeat (40) tick();
    chk("flush_no_done", n_done, d0);
    chk("flush_keep_res", result, 63);

    op(32'hFFFF_FFFF, 32'h2, lat);
    chk("res_ovf", result, 32'hFFFF_FFFE);
    op(32'h8000_0000, 32'h2, lat);
    chk("res_sign", result, 0);

`ifndef MUL_SEQUENCER_EARLY_EXIT_EN
    // Start re-pulsed in RUN and in DONE is ignored
    start = 1'b1; src1 = 3; src2 = 3; c0 = cyc_n;
    tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; src1 = 4; src2 = 4;
    tick(); start = 1'b0;
    d0 = n_done;
    repeat (27) tick();
    start = 1'b1;
    #1 chk("ign_done_now", done, 1);
    chk("ign_stall_done", stall, 0);
    tick(); start = 1'b0;
    chk("ign_idle", busy, 0);
    chk("ign_res", result, 9);
    repeat (3) tick();
    chk("ign_single_done", n_done, d0 + 1);
`endif

    // Reset mid-RUN
    start = 1'b1; src1 = 7; src2 = 9;
    tick(); start = 1'b0;
    repeat (RST_CYC - 1) tick();
    rst = 1'b1;
    #1 chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_stall", stall, 0);
    tick(); tick();
    rst = 1'b0;
    d0 = n_done;
    repeat (40) tick();
    chk("mid_rst_no_done", n_done, d0);
    op(32'd3, 32'd4, lat);
    chk("res_3x4", result, 12);

    op(32'd100, 32'd0, lat);
    chk("lat_x0", lat, LAT_0);
    chk("res_x0", result, 0);
    op(32'd100, 32'd1, lat);
    chk("lat_x1", lat, LAT_1);
    chk("res_x1", result, 100);

    // Flush in DONE suppresses the pulse but the result loaded on entry remains
    start = 1'b1; src1 = 2; src2 = 3;
    tick(); start = 1'b0;
    d0 = n_done;
    repeat (LAT_2X3 - 1) tick();
    flush = 1'b1;
    #1 chk("flush_done_pulse", done, 0);
    chk("flush_done_res", result, 6);
    tick(); flush = 1'b0;
    chk("flush_done_idle", busy, 0);
    chk("flush_done_cnt", n_done, d0);

    // Start and flush together in IDLE: flush wins
    start = 1'b1; flush = 1'b1;
    #1 chk("sf_stall", stall, 0);
    tick(); start = 1'b0; flush = 1'b0;
    chk("sf_busy", busy, 0);
    tick();
    chk("sf_busy2", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
